// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, one full-adder step per clock, LSB first; done strobes N+1 cycles after the accepted start.
// No backpressure: start is accepted only in IDLE or DONE and is ignored (not queued) while busy.
module serial_adder #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          last;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  s_sh;
    logic          c;
    logic [CW-1:0] cnt;
    logic          bit_s;
    logic          c_nxt;

    assign bit_s = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last  = (state == RUN) && (cnt == LAST);
    assign sum   = s_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                // A start in the done cycle chains straight into the next addition.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            s_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            s_sh <= '0;
            c    <= cin;
            cnt  <= '0;
            cout <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            // New bit enters at the MSB so bit i reaches sum[i] after N shifts.
            s_sh <= {bit_s, s_sh} >> 1;
            c    <= c_nxt;
            cnt  <= cnt + 1'b1;
            if (last) cout <= c_nxt;
        end
    end
endmodule
